// File: rtl/rr_shift_ctrl_if.sv
// Load stream and shift command bundle for rr_shift_ctrl.
// Optional build macro: RR_SHIFT_CTRL_SERIAL_FILL_EN adds sh_bit_in (serial MSB fill source).
interface rr_shift_ctrl_if #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned CNT_W  = 9
);
   logic              ld_valid;
   logic              ld_ready;
   logic [WORD_W-1:0] ld_data;
   logic              sh_req;
   logic [CNT_W-1:0]  sh_cnt;
   logic              sh_fill;
`ifdef RR_SHIFT_CTRL_SERIAL_FILL_EN
   logic              sh_bit_in;

   modport master (
      output ld_valid, ld_data, sh_req, sh_cnt, sh_fill, sh_bit_in,
      input  ld_ready
   );

   modport slave (
      input  ld_valid, ld_data, sh_req, sh_cnt, sh_fill, sh_bit_in,
      output ld_ready
   );
`else
   modport master (
      output ld_valid, ld_data, sh_req, sh_cnt, sh_fill,
      input  ld_ready
   );

   modport slave (
      input  ld_valid, ld_data, sh_req, sh_cnt, sh_fill,
      output ld_ready
   );
`endif
endinterface

// File: rtl/rr_shift_ctrl.sv
// Sequencer for the 256-bit 16x16 right-shift register of the modular-division datapath.
// Load phase streams 16-bit words into the register (sel_rs=0); shift phase issues a
// programmed number of 1-bit right shifts (sel_rs=1) with an MSB fill bit.
// Optional build macro: RR_SHIFT_CTRL_SERIAL_FILL_EN -- MSB fill comes from sh_bit_in,
// sampled on the edge before each shift cycle, instead of the latched sh_fill.
module rr_shift_ctrl #(
   parameter int unsigned WORDS  = 16,
   parameter int unsigned WORD_W = 16,
   parameter int unsigned CNT_W  = 9
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   rr_shift_ctrl_if.slave    bus,
   output logic [WORD_W-1:0] sr_regin_o,
   output logic              sr_we_o,
   output logic              sr_sel_rs_o,
   output logic              sr_bit256_o,
   output logic [4:0]        word_cnt_o,
   output logic              load_done_o,
   output logic              busy_o,
   output logic              done_o
);

   // Largest meaningful shift run: the full register width.
   localparam logic [CNT_W-1:0] MaxShift = CNT_W'(WORDS * WORD_W);
   localparam logic [4:0]       LastWord = 5'(WORDS - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  rem_q;    // shift cycles still to issue after the current one
   logic [WORD_W-1:0] sr_regin_q;
   logic              sr_we_q;
   logic              sr_sel_rs_q;
   logic              sr_bit256_q;
   logic [4:0]        word_cnt_q;
   logic              load_done_q;
   logic              busy_q;
   logic              done_q;

   logic              sh_accept;
   logic              ld_xfer;
   logic [CNT_W-1:0]  sh_n;
   logic              acc_bit;
   logic              run_bit;

`ifndef RR_SHIFT_CTRL_SERIAL_FILL_EN
   logic              fill_q;
`endif

   // A shift command is only taken between complete operand loads.
   assign sh_accept     = (state_q == StIdle) & bus.sh_req & (word_cnt_q == 5'd0);
   assign bus.ld_ready  = rst_ni & (state_q == StIdle) & ~sh_accept;
   assign ld_xfer       = bus.ld_valid & bus.ld_ready;
   assign sh_n          = (bus.sh_cnt > MaxShift) ? MaxShift : bus.sh_cnt;

   // Fill bit source for the first shift cycle (acc_bit) and the following ones (run_bit).
   always_comb begin
`ifdef RR_SHIFT_CTRL_SERIAL_FILL_EN
      acc_bit = bus.sh_bit_in;
      run_bit = bus.sh_bit_in;
`else
      acc_bit = bus.sh_fill;
      run_bit = fill_q;
`endif
   end

   // Control FSM; every register-side output is produced here as a registered value.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         sr_regin_q  <= '0;
         sr_we_q     <= 1'b0;
         sr_sel_rs_q <= 1'b0;
         sr_bit256_q <= 1'b0;
         word_cnt_q  <= 5'd0;
         load_done_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifndef RR_SHIFT_CTRL_SERIAL_FILL_EN
         fill_q      <= 1'b0;
`endif
      end else begin
         sr_we_q     <= 1'b0;
         sr_sel_rs_q <= 1'b0;
         sr_bit256_q <= 1'b0;
         load_done_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            StIdle: begin
               if (sh_accept) begin
                  busy_q <= 1'b1;
`ifndef RR_SHIFT_CTRL_SERIAL_FILL_EN
                  fill_q <= bus.sh_fill;
`endif
                  if (sh_n == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= StShift;
                     rem_q       <= sh_n - CNT_W'(1);
                     sr_we_q     <= 1'b1;
                     sr_sel_rs_q <= 1'b1;
                     sr_bit256_q <= acc_bit;
                  end
               end else if (ld_xfer) begin
                  sr_we_q     <= 1'b1;
                  sr_regin_q  <= bus.ld_data;
                  load_done_q <= (word_cnt_q == LastWord);
                  word_cnt_q  <= (word_cnt_q == LastWord) ? 5'd0 : word_cnt_q + 5'd1;
               end
            end
            StShift: begin
               if (rem_q != '0) begin
                  rem_q       <= rem_q - CNT_W'(1);
                  sr_we_q     <= 1'b1;
                  sr_sel_rs_q <= 1'b1;
                  sr_bit256_q <= run_bit;
               end else begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sr_regin_o  = sr_regin_q;
   assign sr_we_o     = sr_we_q;
   assign sr_sel_rs_o = sr_sel_rs_q;
   assign sr_bit256_o = sr_bit256_q;
   assign word_cnt_o  = word_cnt_q;
   assign load_done_o = load_done_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
